// File: rtl/aes_sbyte_seq.sv
// Sequential SubBytes/InvSubBytes: LANES table lookups per cycle over a 4*NB-byte state, NCHUNK+1 cycle latency.
// Optional inverse table via macro AES_SBYTE_INV_EN; DONE holds State_out with in_ready low until out_ready.
module aes_sbyte_seq #(
  parameter int NB    = 4,
  parameter int LANES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] State_in [0:4*NB-1],
  input  logic       inv,
  input  logic [7:0] S_Box [0:255],
`ifdef AES_SBYTE_INV_EN
  input  logic [7:0] Inv_S_Box [0:255],
`endif
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] State_out [0:4*NB-1],
  output logic       busy
);
  localparam int NBYTES = 4 * NB;
  localparam int NCHUNK = NBYTES / LANES;
  localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam int IW     = $clog2(NBYTES);
  localparam logic [CW-1:0] LAST = CW'(NCHUNK - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_BUSY, ST_DONE} state_t;

  state_t        r_state, w_state_nxt;
  logic [CW-1:0] r_cnt;
  logic [7:0]    r_work     [0:NBYTES-1];
  logic [7:0]    w_work_nxt [0:NBYTES-1];
  logic [IW-1:0] w_idx      [0:LANES-1];
  logic [7:0]    w_sel      [0:LANES-1];
  logic [7:0]    w_sub      [0:LANES-1];
  logic          w_accept, w_last;

  assign w_accept = (r_state == ST_IDLE) && in_valid;
  assign w_last   = (r_cnt == LAST);

`ifdef AES_SBYTE_INV_EN
  logic r_mode;
  always_ff @(posedge clk or posedge rst) begin
    if (rst)           r_mode <= 1'b0;
    else if (w_accept) r_mode <= inv;
  end
`else
  logic w_unused_inv;
  assign w_unused_inv = inv;
`endif

  // Only the bytes of the current chunk pass through the shared lane lookups.
  always_comb begin
    w_work_nxt = r_work;
    for (int l = 0; l < LANES; l++) begin
      w_idx[l] = IW'(int'(r_cnt) * LANES + l);
      w_sel[l] = r_work[w_idx[l]];
`ifdef AES_SBYTE_INV_EN
      w_sub[l] = r_mode ? Inv_S_Box[w_sel[l]] : S_Box[w_sel[l]];
`else
      w_sub[l] = S_Box[w_sel[l]];
`endif
      w_work_nxt[w_idx[l]] = w_sub[l];
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    in_ready    = 1'b0;
    busy        = 1'b0;
    out_valid   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) w_state_nxt = ST_BUSY;
      end
      ST_BUSY: begin
        busy = 1'b1;
        if (w_last) w_state_nxt = ST_DONE;
      end
      ST_DONE: begin
        out_valid = 1'b1;
        if (out_ready) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == ST_BUSY) r_cnt <= w_last ? '0 : r_cnt + 1'b1;
      else if (w_accept)      r_cnt <= '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                      r_work <= '{default: 8'h00};
    else if (w_accept)            r_work <= State_in;
    else if (r_state == ST_BUSY)  r_work <= w_work_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                State_out <= '{default: 8'h00};
    else if ((r_state == ST_BUSY) && w_last) State_out <= w_work_nxt;
  end
endmodule

// File: tb/tb_aes_sbyte_seq.sv
// Directed bench for aes_sbyte_seq: LANES=4/1/16 instances, table vectors plus backpressure, reset and input-toggle sequences.
`timescale 1ns/1ps
module tb_aes_sbyte_seq;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [7:0] sbox  [0:255];
`ifdef AES_SBYTE_INV_EN
  logic [7:0] isbox [0:255];
`endif
  logic [7:0] st_in [0:15];
  logic       inv;
  logic       iv [3];
  logic       ordy [3];
  logic       ir [3];
  logic       ov [3];
  logic       bz [3];
  logic [7:0] so0 [0:15];
  logic [7:0] so1 [0:15];
  logic [7:0] so2 [0:15];
  int n_cmp = 0;
  int n_err = 0;

  aes_sbyte_seq #(.NB(4), .LANES(4)) u_dut (
    .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(ir[0]), .State_in(st_in), .inv(inv), .S_Box(sbox),
`ifdef AES_SBYTE_INV_EN
    .Inv_S_Box(isbox),
`endif
    .out_valid(ov[0]), .out_ready(ordy[0]), .State_out(so0), .busy(bz[0]));

  aes_sbyte_seq #(.NB(4), .LANES(1)) u_l1 (
    .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(ir[1]), .State_in(st_in), .inv(inv), .S_Box(sbox),
`ifdef AES_SBYTE_INV_EN
    .Inv_S_Box(isbox),
`endif
    .out_valid(ov[1]), .out_ready(ordy[1]), .State_out(so1), .busy(bz[1]));

  aes_sbyte_seq #(.NB(4), .LANES(16)) u_l16 (
    .clk(clk), .rst(rst), .in_valid(iv[2]), .in_ready(ir[2]), .State_in(st_in), .inv(inv), .S_Box(sbox),
`ifdef AES_SBYTE_INV_EN
    .Inv_S_Box(isbox),
`endif
    .out_valid(ov[2]), .out_ready(ordy[2]), .State_out(so2), .busy(bz[2]));

  typedef struct {
    logic [127:0] din;
    logic         inv;
    logic [127:0] exp;
  } vec_t;
  vec_t vt[$];

  localparam logic [127:0] ROW0_IN  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] ROW0_OUT = 128'h637c777bf26b6fc53001672bfed7ab76;
  localparam logic [127:0] ROW1_IN  = 128'h101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] ROW1_OUT = 128'hca82c97dfa5947f0add4a2af9ca472c0;

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, aa, bb;
    p = '0; aa = a; bb = b;
    for (int i = 0; i < 8; i++) begin
      if (bb[0]) p = p ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
      bb = bb >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] v, input int s);
    return (v << s) | (v >> (8 - s));
  endfunction

  function automatic int nch(input int d);
    return (d == 0) ? 4 : ((d == 1) ? 16 : 1);
  endfunction

  function automatic logic [127:0] pk(input int d);
    logic [127:0] r;
    r = '0;
    for (int k = 0; k < 16; k++) begin
      case (d)
        0:       r[127-8*k -: 8] = so0[k];
        1:       r[127-8*k -: 8] = so1[k];
        default: r[127-8*k -: 8] = so2[k];
      endcase
    end
    return r;
  endfunction

  task automatic set_in(input logic [127:0] v);
    for (int k = 0; k < 16; k++) st_in[k] = v[127-8*k -: 8];
  endtask

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Called at a negedge with all active instances idle; returns at a negedge.
  task automatic run_vec(input string name, input logic [127:0] din, input logic i_inv,
                         input logic [127:0] exp, input bit all3, input bit scramble);
    int lat [3];
    int nb [3];
    logic [127:0] res [3];
    bit act [3];
    for (int d = 0; d < 3; d++) begin
      act[d] = all3 || (d == 0);
      lat[d] = -1; nb[d] = 0; res[d] = '0;
      if (act[d]) chk($sformatf("%s L%0d in_ready idle", name, 16 / nch(d)), 128'(ir[d]), 128'd1);
    end
    set_in(din);
    inv = i_inv;
    for (int d = 0; d < 3; d++) begin
      iv[d]   = act[d];
      ordy[d] = 1'b1;
    end
    tick();
    for (int d = 0; d < 3; d++) iv[d] = 1'b0;
    for (int n = 1; n <= 20; n++) begin
      for (int d = 0; d < 3; d++) begin
        if (bz[d]) nb[d]++;
        if (ov[d] && lat[d] < 0) begin
          lat[d] = n;
          res[d] = pk(d);
        end
      end
      if (scramble && n <= 3) begin
        set_in({$urandom, $urandom, $urandom, $urandom});
        inv   = ~inv;
        iv[0] = 1'b1;
      end else begin
        iv[0] = 1'b0;
      end
      tick();
    end
    for (int d = 0; d < 3; d++) begin
      if (act[d]) begin
        chk($sformatf("%s L%0d data", name, 16 / nch(d)), res[d], exp);
        chk($sformatf("%s L%0d latency", name, 16 / nch(d)), 128'(lat[d]), 128'(nch(d) + 1));
        chk($sformatf("%s L%0d busy cycles", name, 16 / nch(d)), 128'(nb[d]), 128'(nch(d)));
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst = 1'b1;
    inv = 1'b0;
    set_in('0);
    for (int d = 0; d < 3; d++) begin
      iv[d] = 1'b0; ordy[d] = 1'b0;
    end
    for (int i = 0; i < 256; i++) begin
      logic [7:0] x, b;
      x = 8'(i);
      b = 8'h01;
      for (int j = 0; j < 254; j++) b = gmul(b, x);
      sbox[i] = b ^ rotl(b, 1) ^ rotl(b, 2) ^ rotl(b, 3) ^ rotl(b, 4) ^ 8'h63;
    end
`ifdef AES_SBYTE_INV_EN
    for (int i = 0; i < 256; i++) isbox[sbox[i]] = 8'(i);
`endif

    vt.push_back('{din: {16{8'h00}}, inv: 1'b0, exp: {16{8'h63}}});
    vt.push_back('{din: ROW0_IN,     inv: 1'b0, exp: ROW0_OUT});
    vt.push_back('{din: ROW1_IN,     inv: 1'b0, exp: ROW1_OUT});
    vt.push_back('{din: {16{8'h53}}, inv: 1'b0, exp: {16{8'hed}}});
`ifdef AES_SBYTE_INV_EN
    vt.push_back('{din: {16{8'h63}}, inv: 1'b1, exp: {16{8'h00}}});
    vt.push_back('{din: {16{8'hed}}, inv: 1'b1, exp: {16{8'h53}}});
    vt.push_back('{din: ROW0_OUT,    inv: 1'b1, exp: ROW0_IN});
    vt.push_back('{din: ROW1_OUT,    inv: 1'b1, exp: ROW1_IN});
`else
    vt.push_back('{din: {16{8'h00}}, inv: 1'b1, exp: {16{8'h63}}});
`endif

    // Reset state
    @(negedge clk);
    @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("reset ctl dut%0d", d), 128'({ir[d], ov[d], bz[d]}), 128'(3'b100));
      chk($sformatf("reset data dut%0d", d), pk(d), '0);
    end
    rst = 1'b0;
    tick();

    foreach (vt[i]) run_vec($sformatf("vec%0d", i), vt[i].din, vt[i].inv, vt[i].exp, 1'b1, 1'b0);

    // Backpressure: hold DONE for 10 cycles, stray in_valid must not be taken
    set_in(ROW1_IN);
    inv = 1'b0;
    iv[0] = 1'b1;
    ordy[0] = 1'b0;
    tick();
    iv[0] = 1'b0;
    n = 0;
    while (!ov[0] && n < 20) begin
      tick();
      n++;
    end
    chk("bp reached done", 128'(ov[0]), 128'd1);
    for (int c = 0; c < 10; c++) begin
      chk($sformatf("bp hold ctl c%0d", c), 128'({ov[0], ir[0], bz[0]}), 128'(3'b100));
      chk($sformatf("bp hold data c%0d", c), pk(0), ROW1_OUT);
      if (c == 3) begin
        iv[0] = 1'b1;
        set_in({16{8'hff}});
      end else begin
        iv[0] = 1'b0;
      end
      tick();
    end
    ordy[0] = 1'b1;
    tick();
    chk("bp released ctl", 128'({ov[0], ir[0], bz[0]}), 128'(3'b010));
    chk("bp result kept", pk(0), ROW1_OUT);
    tick();
    chk("bp no late accept", 128'({ir[0], bz[0]}), 128'(2'b10));

    // Reset asserted while chunk 2 is in flight
    set_in(ROW0_IN);
    iv[0] = 1'b1;
    tick();
    iv[0] = 1'b0;
    tick();
    tick();
    chk("rst mid-busy precondition", 128'(bz[0]), 128'd1);
    rst = 1'b1;
    #1;
    chk("rst mid-busy ctl", 128'({ov[0], ir[0], bz[0]}), 128'(3'b010));
    chk("rst mid-busy data", pk(0), '0);
    @(negedge clk);
    rst = 1'b0;
    tick();
    run_vec("post-reset", ROW1_IN, 1'b0, ROW1_OUT, 1'b0, 1'b0);

    // inv and State_in toggled during BUSY must not affect the result
    run_vec("toggle", ROW0_IN, 1'b0, ROW0_OUT, 1'b0, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
